// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR with seed load, lock-up recovery and
// on-line measurement of the sequence period.
module lfsr_gen #(
   parameter int unsigned           WIDTH        = 16,
   parameter logic [WIDTH-1:0]      TAPS         = 16'hB400,
   parameter bit                    GALOIS       = 1'b0,
   parameter logic [WIDTH-1:0]      SEED_DEFAULT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             period_valid,
   output logic             lockup
);

   logic [WIDTH-1:0] active_seed;
   logic [WIDTH-1:0] step_cnt;
   logic [WIDTH-1:0] step_cnt_inc;
   logic [WIDTH-1:0] next_q;

   assign step_cnt_inc = step_cnt + WIDTH'(1);
   assign bit_out      = GALOIS ? q[0] : q[WIDTH-1];

   always_comb begin
      // NOTE: next_q gets a value on every path so no latch is inferred.
      next_q = '0;
      if (GALOIS) begin
         next_q = {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : '0);
      end else begin
         next_q = {q[WIDTH-2:0], ^(q & TAPS)};
      end
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         q            <= SEED_DEFAULT;
         active_seed  <= SEED_DEFAULT;
         step_cnt     <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         wrap         <= 1'b0;
         lockup       <= 1'b0;
      end else begin
         wrap   <= 1'b0;
         lockup <= 1'b0;
         if (load) begin
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            if (seed == '0) begin
               q           <= SEED_DEFAULT;
               active_seed <= SEED_DEFAULT;
               lockup      <= 1'b1;
            end else begin
               q           <= seed;
               active_seed <= seed;
            end
         end else if (en) begin
            if (next_q == '0) begin
               // Degenerate taps collapsed the state: restart from the seed.
               q        <= active_seed;
               lockup   <= 1'b1;
               step_cnt <= '0;
            end else if (next_q == active_seed) begin
               q            <= next_q;
               wrap         <= 1'b1;
               period       <= step_cnt_inc;
               period_valid <= 1'b1;
               step_cnt     <= '0;
            end else begin
               q        <= next_q;
               step_cnt <= step_cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: four instances (16-bit default, 4-bit
// Fibonacci, 4-bit Galois, 4-bit degenerate taps) checked against a scoreboard.
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  rst_v  = 4'hF;
   logic [3:0]  en_v   = 4'h0;
   logic [3:0]  load_v = 4'h0;
   logic [15:0] seed0  = '0;
   logic [3:0]  seed1  = '0, seed2 = '0, seed3 = '0;

   logic [15:0] q0, p0;
   logic [3:0]  q1, p1, q2, p2, q3, p3;
   logic        bo0, bo1, bo2, bo3, wr0, wr1, wr2, wr3;
   logic        pv0, pv1, pv2, pv3, lk0, lk1, lk2, lk3;

   lfsr_gen u_d0 (.clk(clk), .rst(rst_v[0]), .en(en_v[0]), .load(load_v[0]), .seed(seed0),
                  .q(q0), .bit_out(bo0), .wrap(wr0), .period(p0), .period_valid(pv0), .lockup(lk0));
   lfsr_gen #(.WIDTH(4), .TAPS(4'b1001), .GALOIS(1'b0), .SEED_DEFAULT(4'b0001)) u_d1 (
      .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .load(load_v[1]), .seed(seed1),
      .q(q1), .bit_out(bo1), .wrap(wr1), .period(p1), .period_valid(pv1), .lockup(lk1));
   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .GALOIS(1'b1), .SEED_DEFAULT(4'b0001)) u_d2 (
      .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .load(load_v[2]), .seed(seed2),
      .q(q2), .bit_out(bo2), .wrap(wr2), .period(p2), .period_valid(pv2), .lockup(lk2));
   lfsr_gen #(.WIDTH(4), .TAPS(4'b0001), .GALOIS(1'b0), .SEED_DEFAULT(4'b0001)) u_d3 (
      .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .load(load_v[3]), .seed(seed3),
      .q(q3), .bit_out(bo3), .wrap(wr3), .period(p3), .period_valid(pv3), .lockup(lk3));

   typedef struct {
      logic [31:0] q, act, cnt, period;
      logic        pv;
   } mstate_t;

   typedef struct {
      int          id;
      logic [31:0] q, period;
      logic        wrap, pv, lockup, bo;
   } exp_t;

   int unsigned w_of [4] = '{16, 4, 4, 4};
   logic [31:0] t_of [4] = '{32'hB400, 32'h9, 32'hC, 32'h1};
   bit          g_of [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   mstate_t m [4];
   exp_t    sb [$];
   int      n_vec = 0;
   int      n_bad = 0;

   logic [3:0] fib4_seq [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                                 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
   logic [3:0] gal4_seq [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

   task automatic check(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL d%0d_%s: observed %h expected %h", id, tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] mask_of(int id);
      return (w_of[id] == 32) ? 32'hFFFF_FFFF : ((32'h1 << w_of[id]) - 32'h1);
   endfunction

   function automatic logic [31:0] seed_of(int id);
      case (id)
         0:       return {16'h0, seed0};
         1:       return {28'h0, seed1};
         2:       return {28'h0, seed2};
         default: return {28'h0, seed3};
      endcase
   endfunction

   function automatic exp_t get_obs(int id);
      exp_t o;
      o.id = id;
      case (id)
         0:       begin o.q = {16'h0, q0}; o.period = {16'h0, p0}; o.wrap = wr0; o.pv = pv0; o.lockup = lk0; o.bo = bo0; end
         1:       begin o.q = {28'h0, q1}; o.period = {28'h0, p1}; o.wrap = wr1; o.pv = pv1; o.lockup = lk1; o.bo = bo1; end
         2:       begin o.q = {28'h0, q2}; o.period = {28'h0, p2}; o.wrap = wr2; o.pv = pv2; o.lockup = lk2; o.bo = bo2; end
         default: begin o.q = {28'h0, q3}; o.period = {28'h0, p3}; o.wrap = wr3; o.pv = pv3; o.lockup = lk3; o.bo = bo3; end
      endcase
      return o;
   endfunction

   // Reference step: Fibonacci feeds the tap parity into bit 0, Galois shifts
   // right and folds the taps in when the outgoing bit is set.
   function automatic logic [31:0] model_next(int id, logic [31:0] s);
      if (g_of[id]) return (s >> 1) ^ (s[0] ? t_of[id] : 32'h0);
      return ((s << 1) | {31'h0, ^(s & t_of[id])}) & mask_of(id);
   endfunction

   function automatic exp_t model_cycle(int id, logic r, logic ld, logic e, logic [31:0] sd);
      exp_t        x;
      logic [31:0] nx;
      x.id = id; x.wrap = 1'b0; x.lockup = 1'b0;
      if (r) begin
         m[id].q = 32'h1; m[id].act = 32'h1; m[id].cnt = 0; m[id].period = 0; m[id].pv = 1'b0;
      end else if (ld) begin
         m[id].cnt = 0; m[id].period = 0; m[id].pv = 1'b0;
         if (sd == 0) begin
            m[id].q = 32'h1; m[id].act = 32'h1; x.lockup = 1'b1;
         end else begin
            m[id].q = sd; m[id].act = sd;
         end
      end else if (e) begin
         nx = model_next(id, m[id].q);
         if (nx == 0) begin
            m[id].q = m[id].act; x.lockup = 1'b1; m[id].cnt = 0;
         end else if (nx == m[id].act) begin
            m[id].q = nx; x.wrap = 1'b1; m[id].period = (m[id].cnt + 1) & mask_of(id);
            m[id].pv = 1'b1; m[id].cnt = 0;
         end else begin
            m[id].q = nx; m[id].cnt = (m[id].cnt + 1) & mask_of(id);
         end
      end
      x.q = m[id].q; x.period = m[id].period; x.pv = m[id].pv;
      x.bo = g_of[id] ? m[id].q[0] : m[id].q[w_of[id]-1];
      return x;
   endfunction

   task automatic tick();
      exp_t e, o;
      for (int i = 0; i < 4; i++) sb.push_back(model_cycle(i, rst_v[i], load_v[i], en_v[i], seed_of(i)));
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = get_obs(e.id);
         check("q", e.id, o.q, e.q);
         check("wrap", e.id, {31'h0, o.wrap}, {31'h0, e.wrap});
         check("lockup", e.id, {31'h0, o.lockup}, {31'h0, e.lockup});
         check("period", e.id, o.period, e.period);
         check("pvalid", e.id, {31'h0, o.pv}, {31'h0, e.pv});
         check("bit_out", e.id, {31'h0, o.bo}, {31'h0, e.bo});
      end
   endtask

   initial begin
      int wraps;
      // Reset outranks a simultaneous load and step.
      load_v = 4'b0010; en_v = 4'b0011; seed1 = 4'h5; seed0 = 16'h1234;
      tick();
      check("rst_q", 1, {28'h0, q1}, 32'h1);
      check("rst_pv", 0, {31'h0, pv0}, 32'h0);
      rst_v = 4'h0; load_v = 4'h0; en_v = 4'h0;
      tick();

      // Full 15-step sequences for the Fibonacci and Galois 4-bit variants.
      en_v = 4'b0110;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("fib_seq", 1, {28'h0, q1}, {28'h0, fib4_seq[i]});
         check("gal_seq", 2, {28'h0, q2}, {28'h0, gal4_seq[i]});
         check("fib_wrap", 1, {31'h0, wr1}, (i == 14) ? 32'h1 : 32'h0);
      end
      check("fib_period", 1, {28'h0, p1}, 32'd15);
      check("gal_period", 2, {28'h0, p2}, 32'd15);
      en_v = 4'h0;

      // Reload mid-sequence with en also high: load wins, new cycle length 15.
      en_v[1] = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      load_v[1] = 1'b1; seed1 = 4'b1010;
      tick();
      check("load_q", 1, {28'h0, q1}, 32'hA);
      check("load_pv", 1, {31'h0, pv1}, 32'h0);
      load_v[1] = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("reload_wrap", 1, {31'h0, wr1}, 32'h1);
      check("reload_q", 1, {28'h0, q1}, 32'hA);
      check("reload_period", 1, {28'h0, p1}, 32'd15);

      // Zero seed with en: substitute seed, lockup pulse, no step.
      load_v[1] = 1'b1; seed1 = 4'h0;
      tick();
      check("zero_q", 1, {28'h0, q1}, 32'h1);
      check("zero_lockup", 1, {31'h0, lk1}, 32'h1);
      load_v[1] = 1'b0; en_v[1] = 1'b0;
      tick();
      check("lockup_clear", 1, {31'h0, lk1}, 32'h0);

      // Degenerate taps: 1000 steps to zero, so the active seed is restored.
      load_v[3] = 1'b1; seed3 = 4'b1000;
      tick();
      load_v[3] = 1'b0; en_v[3] = 1'b1;
      tick();
      check("deg_q", 3, {28'h0, q3}, 32'h8);
      check("deg_lockup", 3, {31'h0, lk3}, 32'h1);
      tick();
      en_v[3] = 1'b0;

      // Reset mid-measurement abandons the period; counting restarts at 0.
      en_v[1] = 1'b1;
      for (int i = 0; i < 15 + 7; i++) tick();
      rst_v[1] = 1'b1;
      tick();
      check("midrst_q", 1, {28'h0, q1}, 32'h1);
      check("midrst_pv", 1, {31'h0, pv1}, 32'h0);
      rst_v[1] = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("restart_period", 1, {28'h0, p1}, 32'd15);
      en_v[1] = 1'b0;

      // Default 16-bit configuration: maximal period 65535.
      wraps = 0;
      en_v[0] = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         tick();
         if (wr0) wraps++;
      end
      check("max_wraps", 0, wraps, 32'd1);
      check("max_wrap_last", 0, {31'h0, wr0}, 32'h1);
      check("max_q", 0, {16'h0, q0}, 32'h1);
      check("max_period", 0, {16'h0, p0}, 32'd65535);
      check("max_pv", 0, {31'h0, pv0}, 32'h1);
      en_v[0] = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
